// File: rtl/i2c_ctrl_pkg.sv
// rtl/i2c_ctrl_pkg.sv - shared register map, bit positions and types for i2c_ctrl_regs
// Purpose: single source for register offsets, field bit positions, response
// codes, prescale reset value and the address decode helper.
// Ports: none (package).
package i2c_ctrl_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_CMD    = 8'h04;
    localparam logic [7:0] ADDR_TXDATA = 8'h08;
    localparam logic [7:0] ADDR_RXDATA = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    localparam int CTRL_STOP_ON_IDLE_BIT = 16;
    localparam int CTRL_IRQ_EN_BIT       = 17;

    localparam int CMD_START_BIT  = 8;
    localparam int CMD_READ_BIT   = 9;
    localparam int CMD_WRITE_BIT  = 10;
    localparam int CMD_WRMULT_BIT = 11;
    localparam int CMD_STOP_BIT   = 12;

    localparam int TX_LAST_BIT  = 8;
    localparam int RX_LAST_BIT  = 8;
    localparam int RX_VALID_BIT = 9;

    localparam int ST_BUSY_BIT        = 0;
    localparam int ST_BUS_CONTROL_BIT = 1;
    localparam int ST_BUS_ACTIVE_BIT  = 2;
    localparam int ST_MISSED_ACK_BIT  = 3;
    localparam int ST_TX_FULL_BIT     = 4;
    localparam int ST_TX_EMPTY_BIT    = 5;
    localparam int ST_RX_FULL_BIT     = 6;
    localparam int ST_RX_EMPTY_BIT    = 7;
    localparam int ST_CMD_VALID_BIT   = 8;

    localparam logic [1:0]  RESP_OK        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;
    localparam logic [15:0] PRESCALE_RESET = 16'd250;

    // FIFO entries carry {last, data}
    localparam int FIFO_W = 9;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_CMD,
        REG_TXDATA,
        REG_RXDATA,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    typedef struct packed {
        logic [6:0] address;
        logic       start;
        logic       read;
        logic       write;
        logic       write_multiple;
        logic       stop;
    } cmd_t;

    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        case (addr)
            ADDR_CTRL:   return REG_CTRL;
            ADDR_CMD:    return REG_CMD;
            ADDR_TXDATA: return REG_TXDATA;
            ADDR_RXDATA: return REG_RXDATA;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - synchronous FIFO for {last, data} byte entries
// Purpose: DEPTH-entry FIFO; push ignored when full, pop ignored when empty.
// Fullness is judged on the registered count, so push+pop when full rejects
// the push.
// Ports: clk, rst_n (sync, active-low); push_i/push_data_i; pop_i;
//        pop_data_o (head entry); full_o; empty_o.
module i2c_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i & ~full_o;
    assign pop_ok     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/i2c_ctrl_regs.sv
// rtl/i2c_ctrl_regs.sv - register front end for an I2C master: CTRL/CMD/TX/RX/STATUS
// Purpose: memory-mapped control of an I2C master with a one-entry command
// register, TX/RX byte FIFOs, sticky missed-ack status and an interrupt.
// Ports: clk, rst_n (sync, active-low);
//        ctrl_* : register bus (reads take 2 cycles, writes 1 cycle);
//        cmd_*  : command handshake to the master;
//        data_in*  : TX byte stream out; data_out* : RX byte stream in;
//        busy/bus_control/bus_active/missed_ack : master status inputs;
//        prescale, stop_on_idle : CTRL fields; irq : interrupt.
module i2c_ctrl_regs
    import i2c_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ctrl_address,
    input  logic        ctrl_read,
    input  logic        ctrl_write,
    input  logic [31:0] ctrl_writedata,
    input  logic [3:0]  ctrl_byteenable,
    output logic [31:0] ctrl_readdata,
    output logic [1:0]  ctrl_response,
    output logic        ctrl_waitrequest,
    output logic        irq,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    output logic        data_in_last,
    input  logic        data_in_ready,
    input  logic [7:0]  data_out,
    input  logic        data_out_valid,
    input  logic        data_out_last,
    output logic        data_out_ready,
    input  logic        busy,
    input  logic        bus_control,
    input  logic        bus_active,
    input  logic        missed_ack,
    output logic [15:0] prescale,
    output logic        stop_on_idle
);

    reg_sel_e          sel;
    logic              be0, rd_accept;
    logic              wr_ctrl, wr_cmd, wr_tx, wr_status;
    logic              tx_full, tx_empty, rx_full, rx_empty, rx_pop;
    logic [FIFO_W-1:0] tx_head, rx_head;

    logic [15:0] prescale_q, prescale_d;
    logic        stop_on_idle_q, stop_on_idle_d;
    logic        irq_en_q, irq_en_d;
    cmd_t        cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        sticky_q, sticky_d;
    logic        irq_q, irq_d;
    logic        rd_pending_q;
    logic [31:0] rdata_q, rdata_d, rd_data;
    logic [1:0]  rresp_q, rresp_d, rd_resp, wr_resp;
    logic        unused_ok;

    assign unused_ok = ^{ctrl_writedata[31:18], ctrl_byteenable[3]};

    assign sel       = decode_addr(ctrl_address);
    assign be0       = ctrl_byteenable[0];
    assign rd_accept = ctrl_read & ~rd_pending_q;
    assign wr_ctrl   = ctrl_write & (sel == REG_CTRL);
    assign wr_cmd    = ctrl_write & (sel == REG_CMD) & be0;
    assign wr_tx     = ctrl_write & (sel == REG_TXDATA) & be0;
    assign wr_status = ctrl_write & (sel == REG_STATUS) & be0;
    assign rx_pop    = rd_accept & (sel == REG_RXDATA);

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_W)) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wr_tx),
        .push_data_i ({ctrl_writedata[TX_LAST_BIT], ctrl_writedata[7:0]}),
        .pop_i       (data_in_ready),
        .pop_data_o  (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    i2c_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_W)) u_rx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (data_out_valid),
        .push_data_i ({data_out_last, data_out}),
        .pop_i       (rx_pop),
        .pop_data_o  (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    // Write response is combinational so it lands in the write cycle itself.
    always_comb begin
        wr_resp = RESP_OK;
        case (sel)
            REG_CTRL, REG_STATUS: wr_resp = RESP_OK;
            REG_CMD:    if (be0 && cmd_valid_q) wr_resp = RESP_SLVERR;
            REG_TXDATA: if (be0 && tx_full)     wr_resp = RESP_SLVERR;
            default:    wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OK;
        case (sel)
            REG_CTRL: begin
                rd_data[15:0]                  = prescale_q;
                rd_data[CTRL_STOP_ON_IDLE_BIT] = stop_on_idle_q;
                rd_data[CTRL_IRQ_EN_BIT]       = irq_en_q;
            end
            REG_RXDATA: begin
                if (!rx_empty) begin
                    rd_data[7:0]         = rx_head[7:0];
                    rd_data[RX_LAST_BIT] = rx_head[8];
                    rd_data[RX_VALID_BIT] = 1'b1;
                end
            end
            REG_STATUS: begin
                rd_data[ST_BUSY_BIT]        = busy;
                rd_data[ST_BUS_CONTROL_BIT] = bus_control;
                rd_data[ST_BUS_ACTIVE_BIT]  = bus_active;
                rd_data[ST_MISSED_ACK_BIT]  = sticky_q;
                rd_data[ST_TX_FULL_BIT]     = tx_full;
                rd_data[ST_TX_EMPTY_BIT]    = tx_empty;
                rd_data[ST_RX_FULL_BIT]     = rx_full;
                rd_data[ST_RX_EMPTY_BIT]    = rx_empty;
                rd_data[ST_CMD_VALID_BIT]   = cmd_valid_q;
            end
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        prescale_d     = prescale_q;
        stop_on_idle_d = stop_on_idle_q;
        irq_en_d       = irq_en_q;
        cmd_d          = cmd_q;
        cmd_valid_d    = cmd_valid_q;
        sticky_d       = sticky_q;
        rdata_d        = rdata_q;
        rresp_d        = rresp_q;

        if (wr_ctrl) begin
            if (ctrl_byteenable[0]) prescale_d[7:0]  = ctrl_writedata[7:0];
            if (ctrl_byteenable[1]) prescale_d[15:8] = ctrl_writedata[15:8];
            if (ctrl_byteenable[2]) begin
                stop_on_idle_d = ctrl_writedata[CTRL_STOP_ON_IDLE_BIT];
                irq_en_d       = ctrl_writedata[CTRL_IRQ_EN_BIT];
            end
        end

        // A CMD write in the handshake cycle still sees cmd_valid=1 and is refused.
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end else if (wr_cmd && !cmd_valid_q) begin
            cmd_valid_d          = 1'b1;
            cmd_d.address        = ctrl_writedata[6:0];
            cmd_d.start          = ctrl_writedata[CMD_START_BIT];
            cmd_d.read           = ctrl_writedata[CMD_READ_BIT];
            cmd_d.write          = ctrl_writedata[CMD_WRITE_BIT];
            cmd_d.write_multiple = ctrl_writedata[CMD_WRMULT_BIT];
            cmd_d.stop           = ctrl_writedata[CMD_STOP_BIT];
        end

        // Set wins over a simultaneous W1C.
        if (wr_status && ctrl_writedata[ST_MISSED_ACK_BIT]) sticky_d = 1'b0;
        if (missed_ack) sticky_d = 1'b1;

        if (rd_accept) begin
            rdata_d = rd_data;
            rresp_d = rd_resp;
        end
    end

    assign irq_d = irq_en_q & (sticky_q | ~rx_empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_q     <= PRESCALE_RESET;
            stop_on_idle_q <= 1'b0;
            irq_en_q       <= 1'b0;
            cmd_q          <= '0;
            cmd_valid_q    <= 1'b0;
            sticky_q       <= 1'b0;
            irq_q          <= 1'b0;
            rd_pending_q   <= 1'b0;
            rdata_q        <= '0;
            rresp_q        <= RESP_OK;
        end else begin
            prescale_q     <= prescale_d;
            stop_on_idle_q <= stop_on_idle_d;
            irq_en_q       <= irq_en_d;
            cmd_q          <= cmd_d;
            cmd_valid_q    <= cmd_valid_d;
            sticky_q       <= sticky_d;
            irq_q          <= irq_d;
            rd_pending_q   <= rd_accept;
            rdata_q        <= rdata_d;
            rresp_q        <= rresp_d;
        end
    end

    assign ctrl_readdata      = rdata_q;
    assign ctrl_response      = ctrl_write ? wr_resp : rresp_q;
    assign ctrl_waitrequest   = rd_accept;
    assign irq                = irq_q;
    assign cmd_valid          = cmd_valid_q;
    assign cmd_address        = cmd_q.address;
    assign cmd_start          = cmd_q.start;
    assign cmd_read           = cmd_q.read;
    assign cmd_write          = cmd_q.write;
    assign cmd_write_multiple = cmd_q.write_multiple;
    assign cmd_stop           = cmd_q.stop;
    assign data_in            = tx_head[7:0];
    assign data_in_last       = tx_head[8];
    assign data_in_valid      = ~tx_empty;
    assign data_out_ready     = ~rx_full;
    assign prescale           = prescale_q;
    assign stop_on_idle       = stop_on_idle_q;

endmodule

// File: tb/tb_i2c_ctrl_regs.sv
// tb/tb_i2c_ctrl_regs.sv - self-checking bench for i2c_ctrl_regs
module tb_i2c_ctrl_regs;

    localparam int FIFO_DEPTH = 4;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic        clk, rst_n;
    logic [7:0]  ctrl_address;
    logic        ctrl_read, ctrl_write;
    logic [31:0] ctrl_writedata;
    logic [3:0]  ctrl_byteenable;
    logic [31:0] ctrl_readdata;
    logic [1:0]  ctrl_response;
    logic        ctrl_waitrequest, irq;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
    logic [7:0]  data_in;
    logic        data_in_valid, data_in_last, data_in_ready;
    logic [7:0]  data_out;
    logic        data_out_valid, data_out_last, data_out_ready;
    logic        busy, bus_control, bus_active, missed_ack;
    logic [15:0] prescale;
    logic        stop_on_idle;

    i2c_ctrl_regs #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_byteenable(ctrl_byteenable),
        .ctrl_readdata(ctrl_readdata), .ctrl_response(ctrl_response),
        .ctrl_waitrequest(ctrl_waitrequest), .irq(irq),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
        .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_last(data_out_last),
        .data_out_ready(data_out_ready),
        .busy(busy), .bus_control(bus_control), .bus_active(bus_active), .missed_ack(missed_ack),
        .prescale(prescale), .stop_on_idle(stop_on_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  txq[$];
    logic [8:0]  rxq[$];
    logic        m_cmd_valid, m_soi, m_irq_en, m_sticky, m_irq, m_pending;
    logic [12:0] m_cmd;
    logic [15:0] m_prescale;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    function automatic logic [1:0] m_wr_resp();
        case (ctrl_address)
            8'h00, 8'h10: return OK;
            8'h04: return (ctrl_byteenable[0] && m_cmd_valid) ? ERR : OK;
            8'h08: return (ctrl_byteenable[0] && txq.size() == FIFO_DEPTH) ? ERR : OK;
            default: return ERR;
        endcase
    endfunction

    task automatic m_read_value(output logic [31:0] d, output logic [1:0] r);
        d = 0;
        r = OK;
        case (ctrl_address)
            8'h00: d = {14'd0, m_irq_en, m_soi, m_prescale};
            8'h0C: if (rxq.size() != 0) d = 32'h200 | 32'(rxq[0]);
            8'h10: d = 32'(busy) | (32'(bus_control) << 1) | (32'(bus_active) << 2)
                     | (32'(m_sticky) << 3) | (32'(txq.size() == FIFO_DEPTH) << 4)
                     | (32'(txq.size() == 0) << 5) | (32'(rxq.size() == FIFO_DEPTH) << 6)
                     | (32'(rxq.size() == 0) << 7) | (32'(m_cmd_valid) << 8);
            default: r = ERR;
        endcase
    endtask

    task automatic model_step();
        logic        wr, nirq, acc, tx_push, tx_pop, rx_push, rx_pop;
        logic [31:0] rd;
        logic [1:0]  rr;
        if (!rst_n) begin
            txq.delete(); rxq.delete();
            m_cmd_valid = 0; m_cmd = 0; m_prescale = 16'd250; m_soi = 0; m_irq_en = 0;
            m_sticky = 0; m_irq = 0; m_pending = 0; m_rdata = 0; m_rresp = OK;
            return;
        end
        nirq    = m_irq_en && (m_sticky || rxq.size() != 0);
        acc     = ctrl_read && !m_pending;
        wr      = ctrl_write && ctrl_byteenable[0];
        m_read_value(rd, rr);
        tx_push = wr && ctrl_address == 8'h08 && txq.size() < FIFO_DEPTH;
        tx_pop  = data_in_ready && txq.size() != 0;
        rx_push = data_out_valid && rxq.size() < FIFO_DEPTH;
        rx_pop  = acc && ctrl_address == 8'h0C && rxq.size() != 0;
        if (tx_pop) void'(txq.pop_front());
        if (tx_push) txq.push_back(ctrl_writedata[8:0]);
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back({data_out_last, data_out});
        if (m_cmd_valid && cmd_ready) m_cmd_valid = 0;
        else if (wr && ctrl_address == 8'h04 && !m_cmd_valid) begin
            m_cmd_valid = 1;
            m_cmd = ctrl_writedata[12:0];
        end
        if (wr && ctrl_address == 8'h10 && ctrl_writedata[3]) m_sticky = 0;
        if (missed_ack) m_sticky = 1;
        if (ctrl_write && ctrl_address == 8'h00) begin
            if (ctrl_byteenable[0]) m_prescale[7:0]  = ctrl_writedata[7:0];
            if (ctrl_byteenable[1]) m_prescale[15:8] = ctrl_writedata[15:8];
            if (ctrl_byteenable[2]) begin
                m_soi = ctrl_writedata[16];
                m_irq_en = ctrl_writedata[17];
            end
        end
        if (acc) begin
            m_rdata = rd;
            m_rresp = rr;
        end
        m_pending = acc;
        m_irq = nirq;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(m_cmd_valid));
            if (m_cmd_valid) begin
                chk("cmd_address", 32'(cmd_address), 32'(m_cmd[6:0]));
                chk("cmd_flags", 32'({cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop}),
                    32'({m_cmd[8], m_cmd[9], m_cmd[10], m_cmd[11], m_cmd[12]}));
            end
            chk("data_in_valid", 32'(data_in_valid), 32'(txq.size() != 0));
            if (txq.size() != 0) chk("data_in", 32'({data_in_last, data_in}), 32'(txq[0]));
            chk("data_out_ready", 32'(data_out_ready), 32'(rxq.size() < FIFO_DEPTH));
            chk("prescale", 32'(prescale), 32'(m_prescale));
            chk("stop_on_idle", 32'(stop_on_idle), 32'(m_soi));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("waitrequest", 32'(ctrl_waitrequest), 32'(ctrl_read && !m_pending));
            if (ctrl_write) chk("wr_response", 32'(ctrl_response), 32'(m_wr_resp()));
            else if (m_pending) begin
                chk("rd_response", 32'(ctrl_response), 32'(m_rresp));
                chk("readdata", ctrl_readdata, m_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             output logic [1:0] resp);
        ctrl_address = a; ctrl_writedata = d; ctrl_byteenable = be; ctrl_write = 1;
        @(negedge clk);
        resp = ctrl_response;
        tick();
        ctrl_write = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        ctrl_address = a; ctrl_read = 1;
        @(negedge clk);
        chk("read_wait_first", 32'(ctrl_waitrequest), 32'd1);
        tick();
        @(negedge clk);
        d = ctrl_readdata;
        r = ctrl_response;
        tick();
        ctrl_read = 0;
    endtask

    logic [1:0]  r;
    logic [31:0] d;
    logic [8:0]  exp_tx [4];

    initial begin
        rst_n = 0; ctrl_address = 0; ctrl_read = 0; ctrl_write = 0; ctrl_writedata = 0;
        ctrl_byteenable = 0; cmd_ready = 0; data_in_ready = 0; data_out = 0;
        data_out_valid = 0; data_out_last = 0; busy = 1; bus_control = 0; bus_active = 1;
        missed_ack = 0;
        exp_tx[0] = 9'h0A1; exp_tx[1] = 9'h0A2; exp_tx[2] = 9'h0A3; exp_tx[3] = 9'h1A4;
        tick(); tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_prescale", 32'(prescale), 32'd250);
        chk("rst_data_in_valid", 32'(data_in_valid), 32'd0);
        chk("rst_data_out_ready", 32'(data_out_ready), 32'd1);
        chk("rst_waitrequest", 32'(ctrl_waitrequest), 32'd0);
        chk("rst_resp_rdata", {ctrl_readdata[29:0], ctrl_response}, 32'd0);
        tick();
        rst_n = 1;

        // CTRL write, full and partial byte enables
        bus_write(8'h00, 32'h0003_0064, 4'hF, r);
        chk("ctrl_wr_resp", 32'(r), 32'(OK));
        @(negedge clk);
        chk("ctrl_prescale", 32'(prescale), 32'h64);
        chk("ctrl_soi", 32'(stop_on_idle), 32'd1);
        tick();
        bus_write(8'h00, 32'hFFFF_FF00, 4'h2, r);
        bus_read(8'h00, d, r);
        chk("ctrl_readback", d, 32'h0003_FF64);

        // Command register hold and refusal
        bus_write(8'h04, 32'h1450, 4'hF, r);
        chk("cmd_wr_resp", 32'(r), 32'(OK));
        repeat (5) tick();
        @(negedge clk);
        chk("cmd_fields", 32'({cmd_valid, cmd_address, cmd_start, cmd_write, cmd_stop}),
            32'({1'b1, 7'h50, 1'b0, 1'b1, 1'b1}));
        tick();
        bus_write(8'h04, 32'h0201, 4'hF, r);
        chk("cmd_busy_resp", 32'(r), 32'(ERR));
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        @(negedge clk);
        chk("cmd_cleared", 32'(cmd_valid), 32'd0);
        tick();
        bus_write(8'h04, 32'h0301, 4'hE, r);
        chk("cmd_be0_off_resp", 32'(r), 32'(OK));
        bus_read(8'h04, d, r);
        chk("cmd_read_err", {d[29:0], r}, 32'(ERR));

        // TX FIFO fill, overflow, full push+pop, drain
        for (int i = 0; i < 5; i++) begin
            bus_write(8'h08, (i == 3) ? 32'h1A4 : 32'hA1 + 32'(i), 4'hF, r);
            chk("tx_push_resp", 32'(r), 32'((i < 4) ? OK : ERR));
        end
        bus_read(8'h10, d, r);
        chk("status_tx_full", d, 32'h95);
        data_in_ready = 1;
        ctrl_address = 8'h08; ctrl_writedata = 32'hA6; ctrl_byteenable = 4'hF; ctrl_write = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("tx_full_pushpop_resp", 32'(ctrl_response), 32'(ERR));
            chk("tx_order", 32'({data_in_last, data_in}), 32'(exp_tx[k]));
            tick();
            ctrl_write = 0;
        end
        @(negedge clk);
        chk("tx_drained", 32'(data_in_valid), 32'd0);
        tick();
        bus_write(8'h08, 32'hB0, 4'hF, r);
        bus_write(8'h08, 32'hB1, 4'hF, r);
        bus_write(8'h08, 32'hB2, 4'hE, r);
        chk("tx_be0_off_resp", 32'(r), 32'(OK));
        tick();

        // RX path and interrupt
        data_out = 8'h3C; data_out_last = 1; data_out_valid = 1;
        tick();
        data_out_valid = 0; data_out_last = 0;
        tick();
        @(negedge clk);
        chk("irq_rx", 32'(irq), 32'd1);
        tick();
        bus_read(8'h0C, d, r);
        chk("rx_read", d, 32'h33C);
        bus_read(8'h0C, d, r);
        chk("rx_read_empty", {d[29:0], r}, 32'd0);
        @(negedge clk);
        chk("irq_dropped", 32'(irq), 32'd0);
        tick();
        data_out_valid = 1;
        for (int i = 0; i < 5; i++) begin
            data_out = 8'h10 + 8'(i);
            tick();
        end
        data_out_valid = 0;
        @(negedge clk);
        chk("rx_full_ready", 32'(data_out_ready), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h0C, d, r);
            chk("rx_drain", d, 32'h210 + 32'(i));
        end

        // Missed-ack sticky bit
        missed_ack = 1;
        tick();
        missed_ack = 0;
        bus_read(8'h10, d, r);
        chk("sticky_set", 32'(d[3]), 32'd1);
        missed_ack = 1;
        bus_write(8'h10, 32'h8, 4'hF, r);
        missed_ack = 0;
        bus_read(8'h10, d, r);
        chk("sticky_set_wins", 32'(d[3]), 32'd1);
        bus_write(8'h10, 32'h8, 4'hE, r);
        bus_read(8'h10, d, r);
        chk("sticky_be0_off", 32'(d[3]), 32'd1);
        bus_write(8'h10, 32'h8, 4'hF, r);
        bus_read(8'h10, d, r);
        chk("sticky_cleared", 32'(d[3]), 32'd0);

        // Unmapped and wrong-direction accesses
        bus_read(8'h14, d, r);
        chk("unmapped_read", {d[29:0], r}, 32'(ERR));
        bus_read(8'h08, d, r);
        chk("txdata_read", {d[29:0], r}, 32'(ERR));
        bus_write(8'h0C, 32'h55, 4'hF, r);
        chk("rxdata_write", 32'(r), 32'(ERR));
        bus_write(8'h03, 32'h55, 4'hF, r);
        chk("unaligned_write", 32'(r), 32'(ERR));

        // Reset mid-transfer
        data_in_ready = 0;
        bus_write(8'h04, 32'h0301, 4'hF, r);
        for (int i = 0; i < 3; i++) bus_write(8'h08, 32'hC0 + 32'(i), 4'hF, r);
        @(negedge clk);
        chk("pre_rst_state", 32'({cmd_valid, data_in_valid}), 32'b11);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("post_rst_data_in_valid", 32'(data_in_valid), 32'd0);
        chk("post_rst_prescale", 32'(prescale), 32'd250);
        chk("post_rst_soi", 32'(stop_on_idle), 32'd0);
        tick();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_ctrl_regs.md
I2C_CTRL_REGS -- requirements
Module: i2c_ctrl_regs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries in each of the TX and RX byte FIFOs (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have ctrl_address, input, 8: byte address; ctrl_read, input, 1; ctrl_write, input, 1; ctrl_writedata, input, 32; ctrl_byteenable, input, 4.
REQ-005 SHALL have ctrl_readdata, output, 32; ctrl_response, output, 2 (00 OK, 10 SLVERR); ctrl_waitrequest, output, 1; irq, output, 1.
REQ-006 SHALL have cmd_address, output, 7; cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid, all output, 1; cmd_ready, input, 1.
REQ-007 SHALL have data_in, output, 8; data_in_valid, output, 1; data_in_last, output, 1; data_in_ready, input, 1: TX byte stream to the I2C master.
REQ-008 SHALL have data_out, input, 8; data_out_valid, input, 1; data_out_last, input, 1; data_out_ready, output, 1: RX byte stream from the I2C master.
REQ-009 SHALL have busy, bus_control, bus_active, missed_ack, all input, 1; prescale, output, 16; stop_on_idle, output, 1.

Function
REQ-010 Register map SHALL be: 0x00 CTRL (RW), 0x04 CMD (W), 0x08 TXDATA (W), 0x0C RXDATA (R), 0x10 STATUS (R, W1C); all other addresses are unmapped.
REQ-011 CTRL SHALL hold prescale[15:0], stop_on_idle[16], irq_en[17], each byte written only where ctrl_byteenable is set.
REQ-012 A write to CMD SHALL load address[6:0], start[8], read[9], write[10], write_multiple[11], and stop[12] into a one-entry command register, and SHALL set cmd_valid the next cycle.
REQ-013 cmd_valid and all cmd_* fields SHALL hold stable until the cycle cmd_valid&cmd_ready; cmd_valid SHALL clear on the following edge.
REQ-014 A write to CMD while cmd_valid=1 SHALL be discarded and SHALL return SLVERR.
REQ-015 A write to TXDATA SHALL push {last[8], data[7:0]} into the TX FIFO; if the FIFO is full, the push SHALL be discarded and SHALL return SLVERR.
REQ-016 TX FIFO head SHALL drive data_in/data_in_last; data_in_valid = ~tx_empty; the FIFO SHALL pop on data_in_valid&data_in_ready.
REQ-017 RX FIFO SHALL push {data_out_last, data_out} on data_out_valid&data_out_ready; data_out_ready = ~rx_full.
REQ-018 A read of RXDATA SHALL return data[7:0], last[8], valid[9]=~rx_empty and pop when non-empty; a read when empty SHALL return 0 with OK.
REQ-019 STATUS SHALL read: busy[0], bus_control[1], bus_active[2], missed_ack_sticky[3], tx_full[4], tx_empty[5], rx_full[6], rx_empty[7], cmd_valid[8].
REQ-020 missed_ack_sticky SHALL set on any cycle missed_ack=1; a write of 1 to STATUS[3] SHALL clear it; a simultaneous set and clear SHALL leave it set.
REQ-021 Reads SHALL have latency 1: ctrl_waitrequest=1 in the first cycle of ctrl_read; in the second cycle readdata and response SHALL be registered and valid, with waitrequest=0.
REQ-022 Writes SHALL complete in one cycle with waitrequest=0, and the response SHALL be valid in that same cycle.
REQ-023 Accesses to unmapped addresses, reads of CMD or TXDATA, and writes to RXDATA SHALL return SLVERR with readdata=0 and no side effect.
REQ-024 Writes to CMD, TXDATA, or STATUS with ctrl_byteenable[0]=0 SHALL be ignored and SHALL return OK.
REQ-025 A simultaneous push and pop on a full TX FIFO SHALL reject the push, because fullness is judged before the pop.
REQ-026 A simultaneous push and pop on a non-empty FIFO SHALL leave its count unchanged.
REQ-027 irq SHALL be registered and equal irq_en & (missed_ack_sticky | ~rx_empty).
REQ-028 prescale and stop_on_idle SHALL be driven directly from the CTRL register.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL empty both FIFOs and clear cmd_valid, all cmd_* fields, missed_ack_sticky, irq_en, irq, ctrl_readdata, ctrl_response, and any pending read.
REQ-030 Reset SHALL load prescale=16'd250 and stop_on_idle=0.
REQ-031 After reset, data_in_valid SHALL be 0, data_out_ready SHALL be 1, and ctrl_waitrequest SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abandon any pending command or bytes without a handshake.

Structure
REQ-033 A shared package i2c_ctrl_pkg SHALL hold the register offsets, the bit positions, the response codes, and the prescale reset value.
REQ-034 One sub-module i2c_byte_fifo SHALL be instantiated twice: a synchronous 9-bit FIFO with push/pop/full/empty, parameterised by FIFO_DEPTH.

Verification
REQ-035 Write CTRL=0x0003_0064 with byteenable=0xF -> prescale=0x0064, stop_on_idle=1, and irq_en=1 next cycle.
REQ-036 Write CMD=0x1450 with cmd_ready=0 for 5 cycles -> cmd_valid=1, cmd_address=0x50, write=1, stop=1 held stable; a second CMD write returns SLVERR; cmd_valid=0 the cycle after cmd_ready=1.
REQ-037 With data_in_ready=0, push 5 TXDATA bytes 0xA1..0xA5 -> the first 4 return OK, the 5th returns SLVERR; releasing ready emits A1..A4 in order.
REQ-038 Drive data_out 0x3C (last=1) -> irq=1; a RXDATA read returns 0x33C after one wait cycle; the next read returns 0 and irq drops.
REQ-039 Pulse missed_ack for 1 cycle -> STATUS[3]=1; a W1C write in the same cycle as a second missed_ack pulse keeps it 1; a later W1C clears it.
REQ-040 Apply rst_n=0 for 1 cycle while cmd_valid=1 and TX holds 3 bytes -> cmd_valid=0, data_in_valid=0, prescale=250.
